store_packer: RTL and testbench
===============================

// Module: store_packer
// PURPOSE
//   Write-side counterpart of the MEM-stage immediate/load extender: narrows a 32-bit register
//   value to the byte/halfword/word lanes of a store. Sits between EX/MEM and data memory,
//   producing word-aligned address, lane-replicated data and byte enables. Flags misaligned
//   stores. Elastic: 2-entry buffer with valid/ready on both sides, 1-cycle latency.
// PARAMETERS
//   CNT_W       16   width of the completed-store counter (wraps)
//   BIG_ENDIAN  0    0: byte k of a word on lane k; 1: byte k on lane 3-k
// PORTS
//   clk            in   1      clock, rising edge
//   rst            in   1      asynchronous reset, active-high
//   in_valid       in   1      upstream request valid
//   in_ready       out  1      buffer can accept (registered)
//   op             in   6      opcode: 6'h28 sb, 6'h29 sh, 6'h2b sw; others are non-stores
//   addr           in   32     byte address
//   wdata          in   32     register value to store (rt)
//   flush          in   1      drop all buffered requests and this cycle's input
//   out_valid      out  1      memory request valid
//   out_ready      in   1      memory accepts request
//   mem_addr       out  32     {addr[31:2],2'b00}
//   mem_wdata      out  32     lane-replicated store data
//   mem_be         out  4      byte enables, one-hot/pair/all
//   misalign       out  1      one-cycle pulse: misaligned store rejected
//   misalign_addr  out  32     byte address of last rejected store (held)
//   store_count    out  CNT_W  count of completed out handshakes
// BEHAVIOUR
//   Reset (async, rst=1): state EMPTY, in_ready=1, out_valid=0, mem_addr/mem_wdata=0,
//     mem_be=0, misalign=0, misalign_addr=0, store_count=0.
//   Accept = in_valid & in_ready & ~flush. Output handshake = out_valid & out_ready.
//   Encoding at accept (k=addr[1:0], lane L = BIG_ENDIAN ? 3-k : k):
//     sb: be=1<<L; wdata_out={4{wdata[7:0]}}.
//     sh: k[0] must be 0; be=4'b0011 (L in {0,1}) else 4'b1100; wdata_out={2{wdata[15:0]}}.
//     sw: k must be 0; be=4'b1111; wdata_out=wdata.
//     Misaligned sh/sw: not enqueued; next cycle misalign=1, misalign_addr<=addr.
//     Non-store op: consumed, not enqueued, no flag.
//   Buffer FSM (entries: HEAD drives outputs, SKID holds overflow):
//     EMPTY: valid store accepted -> ONE (HEAD loaded).
//     ONE:   store in & handshake -> ONE (HEAD replaced); store in, no handshake -> TWO
//            (SKID loaded); no store, handshake -> EMPTY; else stay.
//     TWO:   in_ready=0; handshake -> ONE (SKID moves to HEAD); else stay.
//     in_ready registered: 1 in EMPTY/ONE, 0 in TWO (next-state based, no comb path from out_ready).
//   Latency: store accepted at edge N is out_valid after edge N (visible cycle N+1) if buffer empty.
//   Order: strictly FIFO; outputs stable while out_valid=1 & out_ready=0.
//   out_valid=0 => mem_be=0 (mem_addr/mem_wdata don't care but must not be X).
//   store_count += 1 on every handshake; wraps 2^CNT_W-1 -> 0.
//   flush: next state EMPTY, out_valid=0, input dropped; a handshake in the flush cycle still
//     completes and counts; misalign from the flush-cycle input suppressed. flush beats in_valid.
//   rst mid-operation: all buffered stores lost, counter cleared, immediately (async).
// TESTING
//   sb addr=0x1003 wdata=0xAABBCCDD, out_ready=1 -> next cycle mem_addr=0x1000,
//     mem_wdata=0xDDDDDDDD, mem_be=4'b1000 (BIG_ENDIAN=0) / 4'b0001 (BIG_ENDIAN=1).
//   sh addr=0x2002 wdata=0x1234 -> mem_be=4'b1100, mem_wdata=0x12341234; sw addr=0x2002 ->
//     no out_valid, misalign=1 one cycle, misalign_addr=0x2002.
//   out_ready=0, 3 back-to-back sw (0x0,0x4,0x8) -> in_ready falls after 2nd; release
//     out_ready -> 0x0,0x4 then 0x8 in order, store_count=3, no loss/duplication.
//   2 stores buffered, flush=1 with in_valid=1 -> out_valid=0 next cycle, state EMPTY, count 0.
//   CNT_W=4, 17 handshakes -> store_count=1 (wrap); op=6'h23 (lw) -> consumed, no output.
//   rst asserted asynchronously mid-cycle with TWO entries -> outputs reset before next edge.

Source files
------------

// File: rtl/store_packer_if.sv
// Store-request bus between EX/MEM and data memory: upstream request side,
// flush, and the downstream memory request side, plus status outputs.
interface store_packer_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       op;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic [3:0]       mem_be;
  logic             misalign;
  logic [31:0]      misalign_addr;
  logic [CNT_W-1:0] store_count;

  modport slave (
    input  in_valid, op, addr, wdata, flush, out_ready,
    output in_ready, out_valid, mem_addr, mem_wdata, mem_be,
           misalign, misalign_addr, store_count
  );

  modport master (
    output in_valid, op, addr, wdata, flush, out_ready,
    input  in_ready, out_valid, mem_addr, mem_wdata, mem_be,
           misalign, misalign_addr, store_count
  );
endinterface

// File: rtl/store_packer.sv
// Store packer: narrows a register value to byte/halfword/word store lanes,
// emits word-aligned address + byte enables through a 2-entry elastic buffer.
module store_packer #(
  parameter int CNT_W      = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  store_packer_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } entry_t;

  state_t           r_state, w_next;
  entry_t           r_head, r_skid, w_enc;
  logic             r_in_ready;
  logic             r_misalign;
  logic [31:0]      r_misalign_addr;
  logic [CNT_W-1:0] r_count;

  logic [1:0] w_k, w_lane;
  logic       w_sb, w_sh, w_sw, w_store, w_bad_align;
  logic       w_accept, w_push, w_out_valid, w_hs;

  assign w_sb        = (bus.op == 6'h28);
  assign w_sh        = (bus.op == 6'h29);
  assign w_sw        = (bus.op == 6'h2b);
  assign w_store     = w_sb | w_sh | w_sw;
  assign w_k         = bus.addr[1:0];
  assign w_bad_align = (w_sh & w_k[0]) | (w_sw & (w_k != 2'b00));
  assign w_accept    = bus.in_valid & r_in_ready & ~bus.flush;
  assign w_push      = w_accept & w_store & ~w_bad_align;
  assign w_out_valid = (r_state != EMPTY);
  assign w_hs        = w_out_valid & bus.out_ready;

  // Lane placement of the incoming store.
  always_comb begin
    w_lane      = BIG_ENDIAN ? (2'd3 - w_k) : w_k;
    w_enc.waddr = bus.addr[31:2];
    w_enc.data  = bus.wdata;
    w_enc.be    = 4'b1111;
    if (w_sb) begin
      w_enc.data = {4{bus.wdata[7:0]}};
      w_enc.be   = 4'b0001 << w_lane;
    end else if (w_sh) begin
      w_enc.data = {2{bus.wdata[15:0]}};
      w_enc.be   = w_lane[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Buffer occupancy next-state; flush overrides everything.
  always_comb begin
    w_next = r_state;
    case (r_state)
      EMPTY:   if (w_push) w_next = ONE;
      ONE: begin
        if (w_push && !w_hs)      w_next = TWO;
        else if (!w_push && w_hs) w_next = EMPTY;
      end
      TWO:     if (w_hs) w_next = ONE;
      default: w_next = EMPTY;
    endcase
    if (bus.flush) w_next = EMPTY;
  end

  // State and registered in_ready derived from next state (no out_ready comb path).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next != TWO);
    end
  end

  // HEAD/SKID entry storage; flushed entries are left in place but masked by out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        EMPTY: if (w_push) r_head <= w_enc;
        ONE: begin
          if (w_push && w_hs) r_head <= w_enc;
          else if (w_push)    r_skid <= w_enc;
        end
        TWO:     if (w_hs) r_head <= r_skid;
        default: ;
      endcase
    end
  end

  // Misaligned-store pulse and held address of the last rejected store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign      <= 1'b0;
      r_misalign_addr <= '0;
    end else begin
      r_misalign <= w_accept & w_store & w_bad_align;
      if (w_accept && w_store && w_bad_align) r_misalign_addr <= bus.addr;
    end
  end

  // Completed-handshake counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_count <= '0;
    else if (w_hs) r_count <= r_count + 1'b1;
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.mem_addr      = {r_head.waddr, 2'b00};
  assign bus.mem_wdata     = r_head.data;
  assign bus.mem_be        = w_out_valid ? r_head.be : 4'b0000;
  assign bus.misalign      = r_misalign;
  assign bus.misalign_addr = r_misalign_addr;
  assign bus.store_count   = r_count;
endmodule

// File: tb/tb_store_packer.sv
// Directed bench for store_packer: little-endian DUT plus a big-endian twin
// fed with identical stimulus.
module tb_store_packer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  store_packer_if #(.CNT_W(4)) bus0 ();
  store_packer_if #(.CNT_W(4)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.op        = bus0.op;
  assign bus1.addr      = bus0.addr;
  assign bus1.wdata     = bus0.wdata;
  assign bus1.flush     = bus0.flush;
  assign bus1.out_ready = bus0.out_ready;

  store_packer #(.CNT_W(4), .BIG_ENDIAN(1'b0)) dut_le (.clk(clk), .rst(rst), .bus(bus0));
  store_packer #(.CNT_W(4), .BIG_ENDIAN(1'b1)) dut_be (.clk(clk), .rst(rst), .bus(bus1));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
    bus0.in_valid = v;
    bus0.op       = o;
    bus0.addr     = a;
    bus0.wdata    = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    bus0.flush = 1'b0;
    bus0.out_ready = 1'b0;
    #2;
    total++; if (bus0.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b exp=1", bus0.in_ready); end
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", bus0.out_valid); end
    total++; if (bus0.mem_be !== 4'h0) begin bad++; $display("FAIL rst_be got=%h exp=0", bus0.mem_be); end
    total++; if (bus0.mem_addr !== 32'h0 || bus0.mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_addr_data got=%h/%h exp=0/0", bus0.mem_addr, bus0.mem_wdata); end
    total++; if (bus0.misalign !== 1'b0 || bus0.misalign_addr !== 32'h0) begin bad++; $display("FAIL rst_misalign got=%b/%h exp=0/0", bus0.misalign, bus0.misalign_addr); end
    total++; if (bus0.store_count !== 4'h0) begin bad++; $display("FAIL rst_count got=%0d exp=0", bus0.store_count); end
    rst = 1'b0;
  endtask

  task automatic test_sb();
    bus0.out_ready = 1'b1;
    drive(1'b1, 6'h28, 32'h0000_1003, 32'hAABB_CCDD);
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    total++; if (bus0.out_valid !== 1'b1) begin bad++; $display("FAIL sb_valid got=%b exp=1", bus0.out_valid); end
    total++; if (bus0.mem_addr !== 32'h0000_1000) begin bad++; $display("FAIL sb_addr got=%h exp=00001000", bus0.mem_addr); end
    total++; if (bus0.mem_wdata !== 32'hDDDD_DDDD) begin bad++; $display("FAIL sb_data got=%h exp=dddddddd", bus0.mem_wdata); end
    total++; if (bus0.mem_be !== 4'b1000) begin bad++; $display("FAIL sb_be_le got=%b exp=1000", bus0.mem_be); end
    total++; if (bus1.mem_be !== 4'b0001) begin bad++; $display("FAIL sb_be_be got=%b exp=0001", bus1.mem_be); end
    step();
    total++; if (bus0.out_valid !== 1'b0 || bus0.mem_be !== 4'h0) begin bad++; $display("FAIL sb_drain got=%b/%b exp=0/0000", bus0.out_valid, bus0.mem_be); end
    total++; if (bus0.store_count !== 4'd1) begin bad++; $display("FAIL sb_count got=%0d exp=1", bus0.store_count); end
  endtask

  task automatic test_sh_misalign();
    drive(1'b1, 6'h29, 32'h0000_2002, 32'h0000_1234);
    step();
    total++; if (bus0.mem_be !== 4'b1100) begin bad++; $display("FAIL sh_be_le got=%b exp=1100", bus0.mem_be); end
    total++; if (bus1.mem_be !== 4'b0011) begin bad++; $display("FAIL sh_be_be got=%b exp=0011", bus1.mem_be); end
    total++; if (bus0.mem_wdata !== 32'h1234_1234) begin bad++; $display("FAIL sh_data got=%h exp=12341234", bus0.mem_wdata); end
    drive(1'b1, 6'h2b, 32'h0000_2002, 32'hCAFE_F00D);
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL sw_mis_valid got=%b exp=0", bus0.out_valid); end
    total++; if (bus0.misalign !== 1'b1 || bus0.misalign_addr !== 32'h0000_2002) begin bad++; $display("FAIL sw_mis_flag got=%b/%h exp=1/00002002", bus0.misalign, bus0.misalign_addr); end
    total++; if (bus0.store_count !== 4'd2) begin bad++; $display("FAIL sh_count got=%0d exp=2", bus0.store_count); end
    step();
    total++; if (bus0.misalign !== 1'b0 || bus0.misalign_addr !== 32'h0000_2002) begin bad++; $display("FAIL mis_pulse got=%b/%h exp=0/00002002", bus0.misalign, bus0.misalign_addr); end
  endtask

  task automatic test_back_to_back();
    bus0.out_ready = 1'b0;
    drive(1'b1, 6'h2b, 32'h0000_0000, 32'h1111_1111);
    step();
    total++; if (bus0.in_ready !== 1'b1 || bus0.mem_addr !== 32'h0) begin bad++; $display("FAIL b2b_first got=%b/%h exp=1/00000000", bus0.in_ready, bus0.mem_addr); end
    drive(1'b1, 6'h2b, 32'h0000_0004, 32'h2222_2222);
    step();
    total++; if (bus0.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b exp=0", bus0.in_ready); end
    drive(1'b1, 6'h2b, 32'h0000_0008, 32'h3333_3333);
    step();
    total++; if (bus0.mem_addr !== 32'h0 || bus0.mem_wdata !== 32'h1111_1111 || bus0.mem_be !== 4'hF) begin bad++; $display("FAIL b2b_stall got=%h/%h/%b exp=00000000/11111111/1111", bus0.mem_addr, bus0.mem_wdata, bus0.mem_be); end
    bus0.out_ready = 1'b1;
    step();
    total++; if (bus0.mem_addr !== 32'h4 || bus0.mem_wdata !== 32'h2222_2222 || bus0.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_second got=%h/%h/%b exp=00000004/22222222/1", bus0.mem_addr, bus0.mem_wdata, bus0.in_ready); end
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    total++; if (bus0.mem_addr !== 32'h8 || bus0.mem_wdata !== 32'h3333_3333 || bus0.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_third got=%h/%h/%b exp=00000008/33333333/1", bus0.mem_addr, bus0.mem_wdata, bus0.out_valid); end
    step();
    total++; if (bus0.out_valid !== 1'b0 || bus0.store_count !== 4'd5) begin bad++; $display("FAIL b2b_done got=%b/%0d exp=0/5", bus0.out_valid, bus0.store_count); end
  endtask

  task automatic test_flush();
    bus0.out_ready = 1'b0;
    drive(1'b1, 6'h2b, 32'h0000_0010, 32'hA);
    step();
    drive(1'b1, 6'h2b, 32'h0000_0014, 32'hB);
    step();
    bus0.flush = 1'b1;
    drive(1'b1, 6'h2b, 32'h0000_0018, 32'hC);
    step();
    total++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.mem_be !== 4'h0) begin bad++; $display("FAIL flush_empty got=%b/%b/%b exp=0/1/0000", bus0.out_valid, bus0.in_ready, bus0.mem_be); end
    total++; if (bus0.store_count !== 4'd5) begin bad++; $display("FAIL flush_count got=%0d exp=5", bus0.store_count); end
    drive(1'b1, 6'h2b, 32'h0000_0019, 32'hD);
    step();
    total++; if (bus0.misalign !== 1'b0 || bus0.out_valid !== 1'b0) begin bad++; $display("FAIL flush_mis got=%b/%b exp=0/0", bus0.misalign, bus0.out_valid); end
    bus0.flush = 1'b0;
    drive(1'b1, 6'h28, 32'h0000_0020, 32'hE);
    step();
    bus0.flush = 1'b1;
    bus0.out_ready = 1'b1;
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    step();
    bus0.flush = 1'b0;
    total++; if (bus0.out_valid !== 1'b0 || bus0.store_count !== 4'd6) begin bad++; $display("FAIL flush_hs got=%b/%0d exp=0/6", bus0.out_valid, bus0.store_count); end
  endtask

  task automatic test_nonstore();
    drive(1'b1, 6'h23, 32'h0000_0041, 32'h5555_5555);
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    total++; if (bus0.out_valid !== 1'b0 || bus0.misalign !== 1'b0 || bus0.in_ready !== 1'b1) begin bad++; $display("FAIL lw_ignored got=%b/%b/%b exp=0/0/1", bus0.out_valid, bus0.misalign, bus0.in_ready); end
  endtask

  task automatic test_wrap();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 6'h28, 32'h100 + i, i);
      step();
    end
    total++; if (bus0.store_count !== 4'd0) begin bad++; $display("FAIL wrap_16 got=%0d exp=0", bus0.store_count); end
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    step();
    total++; if (bus0.store_count !== 4'd1 || bus0.out_valid !== 1'b0) begin bad++; $display("FAIL wrap_17 got=%0d/%b exp=1/0", bus0.store_count, bus0.out_valid); end
  endtask

  task automatic test_async_reset();
    bus0.out_ready = 1'b0;
    drive(1'b1, 6'h2b, 32'h0000_0030, 32'h7);
    step();
    drive(1'b1, 6'h2b, 32'h0000_0034, 32'h8);
    step();
    drive(1'b0, 6'h00, 32'h0, 32'h0);
    total++; if (bus0.in_ready !== 1'b0 || bus0.store_count !== 4'd1) begin bad++; $display("FAIL arst_pre got=%b/%0d exp=0/1", bus0.in_ready, bus0.store_count); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus0.out_valid !== 1'b0 || bus0.in_ready !== 1'b1 || bus0.mem_be !== 4'h0 || bus0.store_count !== 4'd0 || bus0.mem_addr !== 32'h0) begin bad++; $display("FAIL arst_now got=%b/%b/%b/%0d/%h exp=0/1/0000/0/00000000", bus0.out_valid, bus0.in_ready, bus0.mem_be, bus0.store_count, bus0.mem_addr); end
    #1;
    rst = 1'b0;
    step();
    total++; if (bus0.out_valid !== 1'b0) begin bad++; $display("FAIL arst_after got=%b exp=0", bus0.out_valid); end
  endtask

  initial begin
    test_reset();
    test_sb();
    test_sh_misalign();
    test_back_to_back();
    test_flush();
    test_nonstore();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
